// File: rtl/fifo_wptr_ctrl_if.sv
// rtl/fifo_wptr_ctrl_if.sv - write-side pointer controller signal bundle
//
// Groups the producer/RAM/CDC-facing signals of fifo_wptr_ctrl.
//   slave  : the controller (fifo_wptr_ctrl) side
//   master : the producer / surrounding FIFO side
// Signals:
//   winc_i          write request from producer
//   rgray_sync_i    Gray read pointer, already synchronized into the write domain
//   ovf_clr_i       clears the sticky overflow flag
//   wen_o           RAM write enable
//   waddr_o         RAM write address
//   wgray_o         registered Gray write pointer, toward the read-domain synchronizer
//   wfull_o         FIFO full
//   walmost_full_o  level at or above the almost-full threshold
//   wlevel_o        conservative fill level
//   wovf_o          sticky overflow (write attempted while full)
interface fifo_wptr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc_i;
  logic [ADDR_WIDTH:0]   rgray_sync_i;
  logic                  ovf_clr_i;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [ADDR_WIDTH:0]   wgray_o;
  logic                  wfull_o;
  logic                  walmost_full_o;
  logic [ADDR_WIDTH:0]   wlevel_o;
  logic                  wovf_o;

  modport slave (
    input  winc_i, rgray_sync_i, ovf_clr_i,
    output wen_o, waddr_o, wgray_o, wfull_o, walmost_full_o, wlevel_o, wovf_o
  );

  modport master (
    output winc_i, rgray_sync_i, ovf_clr_i,
    input  wen_o, waddr_o, wgray_o, wfull_o, walmost_full_o, wlevel_o, wovf_o
  );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// rtl/fifo_wptr_ctrl.sv - async FIFO write-domain pointer controller
//
// Owns the binary write pointer and its registered Gray image, decodes the
// synchronized Gray read pointer, and derives full / almost-full / level /
// sticky overflow. Only wen_o is combinational (winc_i and the full register).
// Ports:
//   clk_i    write-domain clock
//   rst_n_i  asynchronous active-low reset, synchronous release
//   wr_if    fifo_wptr_ctrl_if.slave bundle (see interface file)
module fifo_wptr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  fifo_wptr_ctrl_if.slave  wr_if
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wgray_q;
  logic          wfull_q;
  logic          wafull_q;
  logic [PW-1:0] wlevel_q;
  logic          wovf_q;

  logic          accept;
  logic          ovf_set;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;

  assign accept     = wr_if.winc_i & ~wfull_q;
  assign ovf_set    = wr_if.winc_i & wfull_q;
  assign wbin_next  = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
  assign wgray_next = bin2gray(wbin_next);
  assign rbin       = gray2bin(wr_if.rgray_sync_i);
  assign level_next = wbin_next - rbin;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray that is the read pointer with its top two bits inverted.
  generate
    if (ADDR_WIDTH == 1) begin : g_cmp_narrow
      assign full_cmp = ~wr_if.rgray_sync_i;
    end else begin : g_cmp_wide
      assign full_cmp = {~wr_if.rgray_sync_i[ADDR_WIDTH:ADDR_WIDTH-1],
                          wr_if.rgray_sync_i[ADDR_WIDTH-2:0]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_next;
      wgray_q  <= wgray_next;
      wfull_q  <= (wgray_next == full_cmp);
      wafull_q <= (level_next >= AFULL_T);
      wlevel_q <= level_next;
      // A new overflow wins over a simultaneous clear.
      wovf_q   <= ovf_set | (wovf_q & ~wr_if.ovf_clr_i);
    end
  end

  assign wr_if.wen_o          = accept;
  assign wr_if.waddr_o        = wbin_q[ADDR_WIDTH-1:0];
  assign wr_if.wgray_o        = wgray_q;
  assign wr_if.wfull_o        = wfull_q;
  assign wr_if.walmost_full_o = wafull_q;
  assign wr_if.wlevel_o       = wlevel_q;
  assign wr_if.wovf_o         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb/tb_fifo_wptr_ctrl.sv - self-checking bench for fifo_wptr_ctrl
module tb_fifo_wptr_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wptr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .wr_if   (bus)
  );

  typedef struct packed {
    logic       winc;
    logic [4:0] rgray;
    logic       clr;
    logic       e_wen;
    logic [3:0] e_waddr;
    logic [4:0] e_wgray;
    logic       e_full;
    logic [4:0] e_level;
    logic       e_afull;
    logic       e_ovf;
  } vec_t;

  vec_t vq[$];
  logic [4:0] gseq [16] = '{5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04, 5'h0C,
                            5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08, 5'h18};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.winc_i = 1'b0;
    bus.ovf_clr_i = 1'b0;
    bus.rgray_sync_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wgray"},  bus.wgray_o, 0);
    chk({tag, "_waddr"},  bus.waddr_o, 0);
    chk({tag, "_full"},   bus.wfull_o, 0);
    chk({tag, "_afull"},  bus.walmost_full_o, 0);
    chk({tag, "_level"},  bus.wlevel_o, 0);
    chk({tag, "_ovf"},    bus.wovf_o, 0);
  endtask

  logic [4:0] d1, d2, d3, prev;
  int         wrap_seen;
  logic [4:0] mw, mr, wh1, wh2, lvl;
  logic       mfull, mafull, movf, acc, oset;
  logic       rd_en;

  initial begin
    rst_n = 1'b0;
    bus.winc_i = 1'b0;
    bus.ovf_clr_i = 1'b0;
    bus.rgray_sync_i = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 16 with the read pointer parked at 0.
    for (int k = 1; k <= 16; k++)
      vq.push_back('{1'b1, 5'h00, 1'b0, 1'b1, 4'(k % 16), gseq[k-1],
                     (k == 16), 5'(k), (k >= 12), 1'b0});
    // Writes while full are dropped and set overflow.
    vq.push_back('{1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 5'h18, 1'b1, 5'd16, 1'b1, 1'b1});
    vq.push_back('{1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 5'h18, 1'b1, 5'd16, 1'b1, 1'b1});
    // Clear, then clear together with a rejected write (set wins), then idle.
    vq.push_back('{1'b0, 5'h00, 1'b1, 1'b0, 4'd0, 5'h18, 1'b1, 5'd16, 1'b1, 1'b0});
    vq.push_back('{1'b1, 5'h00, 1'b1, 1'b0, 4'd0, 5'h18, 1'b1, 5'd16, 1'b1, 1'b1});
    vq.push_back('{1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 5'h18, 1'b1, 5'd16, 1'b1, 1'b1});
    // One read while full with winc held: full drops, write still rejected,
    // then accepted next cycle and full reasserts.
    vq.push_back('{1'b1, 5'h01, 1'b0, 1'b0, 4'd0, 5'h18, 1'b0, 5'd15, 1'b1, 1'b1});
    vq.push_back('{1'b1, 5'h01, 1'b0, 1'b1, 4'd1, 5'h19, 1'b1, 5'd16, 1'b1, 1'b1});
    vq.push_back('{1'b0, 5'h01, 1'b1, 1'b0, 4'd1, 5'h19, 1'b1, 5'd16, 1'b1, 1'b0});

    foreach (vq[i]) begin
      @(negedge clk);
      bus.winc_i       = vq[i].winc;
      bus.rgray_sync_i = vq[i].rgray;
      bus.ovf_clr_i    = vq[i].clr;
      #1;
      chk($sformatf("v%0d_wen", i), bus.wen_o, vq[i].e_wen);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_waddr", i), bus.waddr_o, vq[i].e_waddr);
      chk($sformatf("v%0d_wgray", i), bus.wgray_o, vq[i].e_wgray);
      chk($sformatf("v%0d_full", i),  bus.wfull_o, vq[i].e_full);
      chk($sformatf("v%0d_level", i), bus.wlevel_o, vq[i].e_level);
      chk($sformatf("v%0d_afull", i), bus.walmost_full_o, vq[i].e_afull);
      chk($sformatf("v%0d_ovf", i),   bus.wovf_o, vq[i].e_ovf);
    end

    // Wrap: read pointer follows wgray_o three cycles late.
    do_reset();
    d1 = '0; d2 = '0; d3 = '0; prev = '0; wrap_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.winc_i = 1'b1;
      bus.rgray_sync_i = d3;
      @(posedge clk);
      #1;
      chk("wrap_nofull", bus.wfull_o, 0);
      chk("wrap_level_le3", int'(bus.wlevel_o <= 5'd3), 1);
      chk("wrap_gray_1bit", $countones(prev ^ bus.wgray_o), 1);
      if (prev == 5'h10 && bus.wgray_o == 5'h00) wrap_seen = 1;
      d3 = d2; d2 = d1; d1 = bus.wgray_o; prev = bus.wgray_o;
    end
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_final_waddr", bus.waddr_o, 8);

    // Asynchronous reset between edges at level 9.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.winc_i = 1'b1;
      bus.rgray_sync_i = '0;
      @(posedge clk);
      #1;
    end
    chk("arst_pre_level", bus.wlevel_o, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.winc_i = 1'b1;
    #1;
    chk("arst_first_waddr", bus.waddr_o, 0);
    chk("arst_first_wen", bus.wen_o, 1);
    @(posedge clk);
    #1;
    chk("arst_after_wgray", bus.wgray_o, 1);
    chk("arst_after_waddr", bus.waddr_o, 1);

    // Random traffic against a reference model; the read pointer only
    // advances up to the write pointer as it stood two cycles earlier.
    do_reset();
    mw = '0; mr = '0; wh1 = '0; wh2 = '0; mfull = 1'b0; movf = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (((cyc / 1000) % 2) == 1) rd_en = ($urandom_range(3) != 0);
      else                        rd_en = ($urandom_range(3) == 0);
      if (rd_en && (5'(wh2 - mr) != 5'd0)) mr = mr + 5'd1;
      bus.rgray_sync_i = mr ^ (mr >> 1);
      bus.winc_i       = ($urandom_range(3) != 0);
      bus.ovf_clr_i    = ($urandom_range(7) == 0);
      #1;
      chk("rnd_wen", bus.wen_o, int'(bus.winc_i & ~mfull));
      acc    = bus.winc_i & ~mfull;
      oset   = bus.winc_i & mfull;
      mw     = mw + {4'd0, acc};
      lvl    = mw - mr;
      mfull  = (lvl == 5'd16);
      mafull = (lvl >= 5'd12);
      movf   = oset | (movf & ~bus.ovf_clr_i);
      @(posedge clk);
      #1;
      chk("rnd_wgray", bus.wgray_o, int'(mw ^ (mw >> 1)));
      chk("rnd_full",  bus.wfull_o, int'(mfull));
      chk("rnd_level", bus.wlevel_o, int'(lvl));
      chk("rnd_afull", bus.walmost_full_o, int'(mafull));
      chk("rnd_ovf",   bus.wovf_o, int'(movf));
      wh2 = wh1;
      wh1 = mw;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
